// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, 1 or 2 stop bits.
// Define UART_TX_BREAK_EN to add the send_break input and the line-break state.
module uart_tx_frame #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            parity_type,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
`ifdef UART_TX_BREAK_EN
    ,
    input  logic                  send_break
`endif
);

    localparam int unsigned BIT_LAST  = CLKS_PER_BIT - 1;
    localparam int unsigned STOP_LAST = STOP_BITS * CLKS_PER_BIT - 1;
    localparam int unsigned BRK_LAST  = (DATA_WIDTH + 2) * CLKS_PER_BIT - 1;
    localparam int unsigned DIV_W     = $clog2(BRK_LAST + 1);
    localparam int unsigned IDX_W     = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
`ifdef UART_TX_BREAK_EN
        ,
        StBreak
`endif
    } state_e;

    state_e                r_state, w_state_d;
    logic [DIV_W-1:0]      r_div, w_div_d;
    logic [IDX_W-1:0]      r_idx, w_idx_d;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_d;
    logic                  r_par_en, w_par_en_d;
    logic                  r_par, w_par_d;
    logic                  r_tx, w_tx_d;
    logic                  r_busy, w_busy_d;
    logic                  w_bit_end;

    assign w_bit_end  = (r_div == DIV_W'(BIT_LAST));
    assign data_ready = (r_state == StIdle);
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign done       = (r_state == StStop) && (r_div == DIV_W'(STOP_LAST));

    always_comb begin
        w_state_d  = r_state;
        w_div_d    = r_div;
        w_idx_d    = r_idx;
        w_shift_d  = r_shift;
        w_par_en_d = r_par_en;
        w_par_d    = r_par;
        w_tx_d     = r_tx;
        w_busy_d   = r_busy;
        case (r_state)
            StIdle: begin
                w_tx_d   = 1'b1;
                w_busy_d = 1'b0;
                w_div_d  = '0;
                w_idx_d  = '0;
`ifdef UART_TX_BREAK_EN
                if (send_break) begin
                    w_state_d = StBreak;
                    w_tx_d    = 1'b0;
                    w_busy_d  = 1'b1;
                end else
`endif
                if (data_valid) begin
                    w_state_d  = StStart;
                    w_tx_d     = 1'b0;
                    w_busy_d   = 1'b1;
                    w_shift_d  = data_in;
                    // Modes 01 and 10 carry a parity bit; 00 and 11 do not.
                    w_par_en_d = parity_type[0] ^ parity_type[1];
                    w_par_d    = (parity_type == 2'b01) ? ~^data_in : ^data_in;
                end
            end
            StStart: begin
                if (w_bit_end) begin
                    w_div_d   = '0;
                    w_idx_d   = '0;
                    w_state_d = StData;
                    w_tx_d    = r_shift[0];
                end else begin
                    w_div_d = r_div + DIV_W'(1);
                end
            end
            StData: begin
                if (w_bit_end) begin
                    w_div_d = '0;
                    if (r_idx == IDX_W'(DATA_WIDTH - 1)) begin
                        w_idx_d = '0;
                        if (r_par_en) begin
                            w_state_d = StParity;
                            w_tx_d    = r_par;
                        end else begin
                            w_state_d = StStop;
                            w_tx_d    = 1'b1;
                        end
                    end else begin
                        w_idx_d   = r_idx + IDX_W'(1);
                        w_shift_d = r_shift >> 1;
                        w_tx_d    = r_shift[1];
                    end
                end else begin
                    w_div_d = r_div + DIV_W'(1);
                end
            end
            StParity: begin
                if (w_bit_end) begin
                    w_div_d   = '0;
                    w_state_d = StStop;
                    w_tx_d    = 1'b1;
                end else begin
                    w_div_d = r_div + DIV_W'(1);
                end
            end
            StStop: begin
                w_tx_d = 1'b1;
                if (r_div == DIV_W'(STOP_LAST)) begin
                    w_div_d   = '0;
                    w_state_d = StIdle;
                    w_busy_d  = 1'b0;
                end else begin
                    w_div_d = r_div + DIV_W'(1);
                end
            end
`ifdef UART_TX_BREAK_EN
            StBreak: begin
                // Divider saturates at the minimum length; exit once send_break drops.
                w_tx_d = 1'b0;
                if (r_div != DIV_W'(BRK_LAST)) begin
                    w_div_d = r_div + DIV_W'(1);
                end else if (!send_break) begin
                    w_div_d   = '0;
                    w_state_d = StStop;
                    w_tx_d    = 1'b1;
                end
            end
`endif
            default: begin
                w_state_d = StIdle;
                w_div_d   = '0;
                w_tx_d    = 1'b1;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_div    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_div    <= w_div_d;
            r_idx    <= w_idx_d;
            r_shift  <= w_shift_d;
            r_par_en <= w_par_en_d;
            r_par    <= w_par_d;
            r_tx     <= w_tx_d;
            r_busy   <= w_busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three instances (16/1, 4/1, 4/2 clocks-per-bit/stop bits)
// checked cycle by cycle against a bit-list model of the frame.
module tb_uart_tx_frame;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_in;
    logic [1:0]   parity_type;
    logic [2:0]   valid;
    logic [2:0]   ready_w, tx_w, busy_w, done_w;
`ifdef UART_TX_BREAK_EN
    logic [2:0]   brk;
`endif

    int n_vec = 0;
    int n_bad = 0;
    bit exp_bits[$];

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_WIDTH(W), .CLKS_PER_BIT(16), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .parity_type(parity_type),
        .data_valid(valid[0]), .data_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]),
        .done(done_w[0])
`ifdef UART_TX_BREAK_EN
        , .send_break(brk[0])
`endif
    );

    uart_tx_frame #(.DATA_WIDTH(W), .CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .parity_type(parity_type),
        .data_valid(valid[1]), .data_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]),
        .done(done_w[1])
`ifdef UART_TX_BREAK_EN
        , .send_break(brk[1])
`endif
    );

    uart_tx_frame #(.DATA_WIDTH(W), .CLKS_PER_BIT(4), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .data_in(data_in), .parity_type(parity_type),
        .data_valid(valid[2]), .data_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]),
        .done(done_w[2])
`ifdef UART_TX_BREAK_EN
        , .send_break(brk[2])
`endif
    );

    function automatic int cpb(input int d);
        return (d == 0) ? 16 : 4;
    endfunction

    function automatic int stops(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    // Line levels of one frame, one entry per bit period.
    task automatic build_model(input int d, input logic [W-1:0] w, input logic [1:0] pt);
        int ones;
        ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < W; i++) begin
            exp_bits.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (pt == 2'b01) exp_bits.push_back(bit'(ones % 2 == 0));
        else if (pt == 2'b10) exp_bits.push_back(bit'(ones % 2 == 1));
        for (int s = 0; s < stops(d); s++) exp_bits.push_back(1'b1);
    endtask

    task automatic check_idle(input int d, input string name);
        n_vec++;
        if (tx_w[d] !== 1'b1 || busy_w[d] !== 1'b0 || ready_w[d] !== 1'b1 || done_w[d] !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle dut%0d: tx=%b busy=%b ready=%b done=%b, required 1 0 1 0",
                     name, d, tx_w[d], busy_w[d], ready_w[d], done_w[d]);
        end
    endtask

    // Entered and left at a negedge. hold keeps data_valid high into the next frame.
    task automatic send_and_check(input int d, input logic [W-1:0] w, input logic [1:0] pt,
                                  input bit hold, input string name);
        int n, c, len, bad_k, done_k, ndone, hs_bad;
        logic bad_got, bad_exp;
        build_model(d, w, pt);
        c = cpb(d);
        len = c * exp_bits.size();
        n = 0;
        while (ready_w[d] !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (ready_w[d] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready-wait: data_ready=%b, required 1", name, ready_w[d]);
            return;
        end
        data_in     = w;
        parity_type = pt;
        valid[d]    = 1'b1;
        @(posedge clk);
        bad_k = -1; done_k = -1; ndone = 0; hs_bad = 0;
        bad_got = 1'b0; bad_exp = 1'b0;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (bad_k < 0 && tx_w[d] !== exp_bits[(k - 1) / c]) begin
                bad_k = k; bad_got = tx_w[d]; bad_exp = exp_bits[(k - 1) / c];
            end
            if (done_w[d] === 1'b1) begin
                ndone++;
                done_k = k;
            end
            if (busy_w[d] !== 1'b1 || ready_w[d] !== 1'b0) hs_bad++;
            data_in     = W'($urandom);
            parity_type = 2'($urandom);
            if (!hold) valid[d] = (k == len) ? 1'b0 : 1'($urandom);
        end
        n_vec++;
        if (bad_k >= 0) begin
            n_bad++;
            $display("FAIL %s tx: cycle %0d tx=%b, required %b", name, bad_k, bad_got, bad_exp);
        end
        n_vec++;
        if (ndone != 1 || done_k != len) begin
            n_bad++;
            $display("FAIL %s done: %0d pulses, last at cycle %0d, required 1 at cycle %0d",
                     name, ndone, done_k, len);
        end
        n_vec++;
        if (hs_bad != 0) begin
            n_bad++;
            $display("FAIL %s busy/ready: %0d cycles wrong, required busy=1 ready=0 for all %0d",
                     name, hs_bad, len);
        end
        @(negedge clk);
        check_idle(d, name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid = 3'b111;
        data_in = W'($urandom);
        parity_type = 2'b10;
`ifdef UART_TX_BREAK_EN
        brk = 3'b000;
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) check_idle(d, "reset_hold");
        end
        rst = 1'b0;
        valid = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) check_idle(d, "reset_after");
        end
    endtask

    task automatic test_even_parity();
        send_and_check(0, 8'hA5, 2'b10, 1'b0, "even_a5_cpb16");
    endtask

    task automatic test_odd_and_none();
        send_and_check(1, 8'hA5, 2'b01, 1'b0, "odd_a5_cpb4");
        send_and_check(1, 8'hA5, 2'b00, 1'b0, "none_a5_cpb4");
        send_and_check(1, 8'h5A, 2'b11, 1'b0, "none11_5a_cpb4");
    endtask

    task automatic test_back_to_back();
        send_and_check(2, 8'h00, 2'b00, 1'b1, "b2b_00_stop2");
        send_and_check(2, 8'hFF, 2'b00, 1'b0, "b2b_ff_stop2");
    endtask

    task automatic test_reset_midframe();
        int ndone, nhigh_bad;
        data_in = 8'h3C;
        parity_type = 2'b00;
        valid[1] = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            valid[1] = 1'b0;
            data_in = W'($urandom);
        end
        n_vec++;
        if (tx_w[1] !== 1'b1 || busy_w[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset bit3: tx=%b busy=%b, required 1 1", tx_w[1], busy_w[1]);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle(1, "midreset_edge");
        @(negedge clk);
        rst = 1'b0;
        ndone = 0; nhigh_bad = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_w[1] === 1'b1) ndone++;
            if (tx_w[1] !== 1'b1 || busy_w[1] !== 1'b0) nhigh_bad++;
        end
        n_vec++;
        if (ndone != 0 || nhigh_bad != 0) begin
            n_bad++;
            $display("FAIL midreset aftermath: %0d done pulses, %0d non-idle cycles, required 0 0",
                     ndone, nhigh_bad);
        end
        send_and_check(1, 8'h3C, 2'b10, 1'b0, "post_reset_3c");
    endtask

    task automatic test_random();
        int d;
        bit hold, prev_hold;
        logic [W-1:0] w;
        logic [1:0] pt;
        prev_hold = 1'b0;
        d = 0;
        for (int i = 0; i < 12; i++) begin
            if (!prev_hold) d = $urandom_range(0, 2);
            w = W'($urandom);
            pt = 2'($urandom);
            hold = (i < 11) && ($urandom_range(0, 1) == 1);
            send_and_check(d, w, pt, hold, $sformatf("rand%0d_dut%0d", i, d));
            prev_hold = hold;
        end
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break();
        int bad_k, done_k, ndone, hs_bad;
        logic exp_tx;
        data_in = 8'hFF;
        parity_type = 2'b00;
        brk[1] = 1'b1;
        valid[1] = 1'b1;
        @(posedge clk);
        bad_k = -1; done_k = -1; ndone = 0; hs_bad = 0;
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            exp_tx = (k > 40);
            if (bad_k < 0 && tx_w[1] !== exp_tx) bad_k = k;
            if (done_w[1] === 1'b1) begin
                ndone++;
                done_k = k;
            end
            if (busy_w[1] !== 1'b1 || ready_w[1] !== 1'b0) hs_bad++;
            valid[1] = 1'b0;
            if (k == 5) brk[1] = 1'b0;
        end
        n_vec++;
        if (bad_k >= 0) begin
            n_bad++;
            $display("FAIL break tx: cycle %0d tx=%b, required %b", bad_k, tx_w[1], bad_k > 40);
        end
        n_vec++;
        if (ndone != 1 || done_k != 44) begin
            n_bad++;
            $display("FAIL break done: %0d pulses, last at cycle %0d, required 1 at cycle 44",
                     ndone, done_k);
        end
        n_vec++;
        if (hs_bad != 0) begin
            n_bad++;
            $display("FAIL break busy/ready: %0d cycles wrong, required busy=1 ready=0", hs_bad);
        end
        @(negedge clk);
        check_idle(1, "break_end");
    endtask
`endif

    initial begin
        test_reset();
        test_even_parity();
        test_odd_and_none();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
